// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared beat type, state encoding and AXI response codes for the response buffer
package rob_pkg;

  localparam int RB_ID_WIDTH   = 4;
  localparam int RB_DATA_WIDTH = 32;
  localparam int RB_TAG_WIDTH  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } orb_state_e;

  // Field order matches the buffer's internal beat layout (id in the MSBs, tagid in the LSBs).
  typedef struct packed {
    logic [RB_ID_WIDTH-1:0]   id;
    logic [RB_DATA_WIDTH-1:0] data;
    logic [1:0]               resp;
    logic                     last;
    logic [RB_TAG_WIDTH-1:0]  tagid;
  } r_beat_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rtl/rsp_fifo.sv - show-ahead FIFO with extra-MSB wrap pointers, full/empty flags
module rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the cleared pointers make every entry unreachable.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/outgoing_response_buffer.sv
// rtl/outgoing_response_buffer.sv - AXI R beat buffer (FIFO + output register); ORB_STATS_EN adds stat counters
module outgoing_response_buffer
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ID_WIDTH-1:0]           in_id,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [1:0]                    in_resp,
  input  logic                          in_last,
  input  logic [TAG_WIDTH-1:0]          in_tagid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [1:0]                    out_resp,
  output logic                          out_last,
  output logic [TAG_WIDTH-1:0]          out_tagid,
  output logic [$clog2(FIFO_DEPTH+2)-1:0] occupancy,
  output logic                          in_burst
`ifdef ORB_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [15:0]                   stat_bursts,
  output logic [15:0]                   stat_errs
`endif
);

  localparam int OCC_W = $clog2(FIFO_DEPTH+2);

  // Same field order as r_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [TAG_WIDTH-1:0]  tagid;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t      in_beat;
  beat_t      fifo_beat;
  beat_t      out_beat;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       hs;
  orb_state_e state;

  assign in_beat  = {in_id, in_data, in_resp, in_last, in_tagid};
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign hs       = out_valid && out_ready;
  assign pop      = !fifo_empty && (!out_valid || out_ready);

  rsp_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_beat),
    .pop       (pop),
    .pop_data  (fifo_beat),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output register only moves when empty or being accepted, so fields stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_beat  <= fifo_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_id    = out_beat.id;
  assign out_data  = out_beat.data;
  assign out_resp  = out_beat.resp;
  assign out_last  = out_beat.last;
  assign out_tagid = out_beat.tagid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({push, hs})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (hs) begin
      case (state)
        ST_IDLE:  if (!out_last) state <= ST_BURST;
        ST_BURST: if (out_last)  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign in_burst = (state == ST_BURST);

`ifdef ORB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats  <= '0;
      stat_bursts <= '0;
      stat_errs   <= '0;
    end else if (hs) begin
      stat_beats <= stat_beats + 32'd1;
      if (out_last)               stat_bursts <= stat_bursts + 16'd1;
      if (resp_is_err(out_resp))  stat_errs   <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_outgoing_response_buffer.sv
// tb/tb_outgoing_response_buffer.sv - self-checking bench for outgoing_response_buffer against a queue model
module tb_outgoing_response_buffer;
  import rob_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  r_beat_t     drv = '0;
  logic        in_ready, out_valid, out_last, in_burst;
  logic [3:0]  out_id, out_tagid;
  logic [31:0] out_data;
  logic [1:0]  out_resp;
  logic [4:0]  occupancy;
  r_beat_t     got;
`ifdef ORB_STATS_EN
  logic [31:0] stat_beats;
  logic [15:0] stat_bursts, stat_errs;
`endif

  always #5 clk = ~clk;

  outgoing_response_buffer #(
    .ID_WIDTH(4), .DATA_WIDTH(32), .TAG_WIDTH(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_id(drv.id), .in_data(drv.data), .in_resp(drv.resp), .in_last(drv.last), .in_tagid(drv.tagid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_data(out_data), .out_resp(out_resp), .out_last(out_last), .out_tagid(out_tagid),
    .occupancy(occupancy), .in_burst(in_burst)
`ifdef ORB_STATS_EN
    , .stat_beats(stat_beats), .stat_bursts(stat_bursts), .stat_errs(stat_errs)
`endif
  );

  assign got = {out_id, out_data, out_resp, out_last, out_tagid};

  int checks = 0;
  int failures = 0;

  // Model: every beat held by the buffer in order, plus the edge at which it was pushed.
  r_beat_t exp_q[$];
  int      edge_q[$];
  int      edge_cnt = 0;
  bit      exp_burst = 1'b0;

  // A beat becomes visible on the output one edge after it was pushed at the earliest.
  function automatic bit exp_valid();
    return (exp_q.size() > 0) && (edge_q[0] < edge_cnt);
  endfunction

  function automatic bit exp_ready();
    int fifo_cnt;
    fifo_cnt = exp_q.size() - (exp_valid() ? 1 : 0);
    return fifo_cnt < DEPTH;
  endfunction

  function automatic r_beat_t exp_front();
    r_beat_t b;
    b = '0;
    if (exp_q.size() > 0) b = exp_q[0];
    return b;
  endfunction

  task automatic rand_beat(input bit last, input logic [1:0] resp);
    drv.id    = 4'($urandom);
    drv.data  = $urandom;
    drv.resp  = resp;
    drv.last  = last;
    drv.tagid = 4'($urandom);
  endtask

  task automatic tick();
    bit      push, hs;
    r_beat_t b;
    push = in_valid && exp_ready();
    hs   = exp_valid() && out_ready;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (hs) begin
      b = exp_q.pop_front();
      void'(edge_q.pop_front());
      exp_burst = !b.last;
    end
    if (push) begin
      exp_q.push_back(drv);
      edge_q.push_back(edge_cnt);
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    edge_q.delete();
    exp_burst = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    edge_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    assert_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_burst !== 1'b0) begin failures++; $display("FAIL reset_in_burst got=%0b exp=0", in_burst); end
    checks++; if (got !== '0) begin failures++; $display("FAIL reset_out_fields got=%0h exp=0", got); end
    release_reset();
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single_beat();
    r_beat_t sent;
    out_ready = 1'b1;
    rand_beat(1'b1, RESP_OKAY);
    drv.id   = 4'd3;
    drv.data = 32'hA5A5A5A5;
    sent     = drv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_edge1 got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL single_occ_edge1 got=%0d exp=1", occupancy); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid_edge2 got=%0b exp=1", out_valid); end
    checks++; if (got !== sent) begin failures++; $display("FAIL single_fields got=%0h exp=%0h", got, sent); end
    checks++; if (in_burst !== 1'b0) begin failures++; $display("FAIL single_burst got=%0b exp=0", in_burst); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL single_occ_after got=%0d exp=0", occupancy); end
    checks++; if (in_burst !== 1'b0) begin failures++; $display("FAIL single_burst_after got=%0b exp=0", in_burst); end
  endtask

  task automatic test_fill();
    r_beat_t held;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rand_beat(1'($urandom), 2'($urandom));
      in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready beat=%0d got=%0b exp=1", i, in_ready); end
      tick();
    end
    checks++; if (occupancy !== 5'd17) begin failures++; $display("FAIL fill_occ got=%0d exp=17", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0b exp=0", in_ready); end
    held = got;
    rand_beat(1'b0, RESP_OKAY);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_18th_ready got=%0b exp=0", in_ready); end
      checks++; if (occupancy !== 5'd17) begin failures++; $display("FAIL fill_18th_occ got=%0d exp=17", occupancy); end
      checks++; if (out_valid !== 1'b1 || got !== held) begin failures++; $display("FAIL fill_stable got=%0h exp=%0h", got, held); end
    end
    checks++; if (held !== exp_front()) begin failures++; $display("FAIL fill_head got=%0h exp=%0h", held, exp_front()); end
    in_valid = 1'b0;
  endtask

  task automatic test_stream_wrap();
    int guard;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_beat(1'($urandom), 2'($urandom));
      in_valid = 1'b1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid cyc=%0d got=%0b exp=1", i, out_valid); end
      checks++; if (got !== exp_front()) begin failures++; $display("FAIL stream_order cyc=%0d got=%0h exp=%0h", i, got, exp_front()); end
      checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL stream_ready cyc=%0d got=%0b exp=%0b", i, in_ready, exp_ready()); end
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      if (exp_valid()) begin
        checks++; if (got !== exp_front()) begin failures++; $display("FAIL drain_order got=%0h exp=%0h", got, exp_front()); end
      end
      tick();
      guard++;
    end
    checks++; if (guard >= 100) begin failures++; $display("FAIL drain_timeout got=%0d exp=<100", guard); end
    checks++; if (occupancy !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got occ=%0d valid=%0b exp occ=0 valid=0", occupancy, out_valid); end
  endtask

  task automatic test_burst_fsm();
    int sent, guard, high_cycles;
    bit accepted;
    assert_reset();
    release_reset();
    sent = 0; guard = 0; high_cycles = 0;
    while ((sent < 4 || exp_q.size() > 0) && guard < 200) begin
      if (!in_valid && sent < 4) begin
        rand_beat(sent == 3, RESP_OKAY);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom);
      checks++; if (in_burst !== exp_burst) begin failures++; $display("FAIL burst_state cyc=%0d got=%0b exp=%0b", guard, in_burst, exp_burst); end
      if (exp_valid() && out_ready) begin
        checks++; if (got !== exp_front()) begin failures++; $display("FAIL burst_fields got=%0h exp=%0h", got, exp_front()); end
      end
      if (in_burst) high_cycles++;
      accepted = in_valid && exp_ready();
      tick();
      if (accepted) begin
        sent++;
        in_valid = 1'b0;
      end
      guard++;
    end
    checks++; if (guard >= 200) begin failures++; $display("FAIL burst_timeout got=%0d exp=<200", guard); end
    checks++; if (in_burst !== 1'b0) begin failures++; $display("FAIL burst_end got=%0b exp=0", in_burst); end
    checks++; if (high_cycles == 0) begin failures++; $display("FAIL burst_never_high got=%0d exp=>0", high_cycles); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    assert_reset();
    release_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_beat(1'b0, RESP_OKAY);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_burst !== 1'b1) begin failures++; $display("FAIL midrst_pre_burst got=%0b exp=1", in_burst); end
    checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL midrst_pre_occ got=%0d exp=5", occupancy); end
    #2;
    assert_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL midrst_occ got=%0d exp=0", occupancy); end
    checks++; if (in_burst !== 1'b0) begin failures++; $display("FAIL midrst_burst got=%0b exp=0", in_burst); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", in_ready); end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rand_beat(1'($urandom), 2'($urandom));
      checks++; if (out_valid !== exp_valid()) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, out_valid, exp_valid()); end
      checks++; if (occupancy !== 5'(exp_q.size())) begin failures++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", i, occupancy, exp_q.size()); end
      checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", i, in_ready, exp_ready()); end
      checks++; if (in_burst !== exp_burst) begin failures++; $display("FAIL rand_burst cyc=%0d got=%0b exp=%0b", i, in_burst, exp_burst); end
      if (exp_valid()) begin
        checks++; if (got !== exp_front()) begin failures++; $display("FAIL rand_fields cyc=%0d got=%0h exp=%0h", i, got, exp_front()); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

`ifdef ORB_STATS_EN
  task automatic test_stats();
    int guard;
    assert_reset();
    release_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 2; k++) begin
        rand_beat(k == 1, (b == 1) ? RESP_SLVERR : RESP_OKAY);
        in_valid = 1'b1;
        tick();
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    checks++; if (stat_beats !== 32'd6) begin failures++; $display("FAIL stat_beats got=%0d exp=6", stat_beats); end
    checks++; if (stat_bursts !== 16'd3) begin failures++; $display("FAIL stat_bursts got=%0d exp=3", stat_bursts); end
    checks++; if (stat_errs !== 16'd2) begin failures++; $display("FAIL stat_errs got=%0d exp=2", stat_errs); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_fill();
    test_stream_wrap();
    test_burst_fsm();
    test_reset_mid_burst();
    test_random();
`ifdef ORB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/outgoing_response_buffer.md
OUTGOING_RESPONSE_BUFFER -- requirements
Module: outgoing_response_buffer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: R-beat ID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: R-beat data width.
REQ-003 SHALL have parameter TAG_WIDTH, default 4: internal tag width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: beat storage; power of 2, minimum 2.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock.
REQ-006 SHALL have rst_n in 1: asynchronous assert, active-low reset.
REQ-007 SHALL have in_valid in 1: internal reorder unit offers a beat.
REQ-008 SHALL have in_ready out 1: buffer accepts the beat.
REQ-009 SHALL have in_id in ID_WIDTH, in_data in DATA_WIDTH, in_resp in 2, in_last in 1 and in_tagid in TAG_WIDTH: beat fields.
REQ-010 SHALL have out_valid out 1 and out_ready in 1: AXI R channel handshake to the external master.
REQ-011 SHALL have out_id, out_data, out_resp, out_last and out_tagid as outputs, with widths as the matching inputs: registered beat fields.
REQ-012 SHALL have occupancy out $clog2(FIFO_DEPTH+2): beats held, counting FIFO plus output register.
REQ-013 SHALL have in_burst out 1: an output burst has started and its last beat is not yet accepted.

Function
REQ-014 SHALL push a beat on in_valid && in_ready; in_ready = !fifo_full, with no combinational dependence on in_valid.
REQ-015 SHALL use a show-ahead FIFO followed by one output register; capacity FIFO_DEPTH+1 beats.
REQ-016 SHALL load the output register when the FIFO is non-empty and (!out_valid || out_ready); this pops the FIFO in the same cycle.
REQ-017 SHALL hold out_valid and all out_* fields stable while out_valid && !out_ready (AXI rule).
REQ-018 SHALL clear out_valid after a handshake when the FIFO is empty.
REQ-019 SHALL present a beat pushed at edge k into an empty buffer as out_valid=1 after edge k+1.
REQ-020 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-021 SHALL preserve beat order exactly; fields pass unmodified.
REQ-022 SHALL allow push and pop in the same cycle when full; in_ready stays 0 in that cycle because it is based on full.
REQ-023 SHALL update occupancy per edge: +1 on push, -1 on output handshake, unchanged when both or neither occur; it never exceeds FIFO_DEPTH+1.
REQ-024 SHALL run a state machine with states IDLE and BURST, following output handshakes only.
REQ-025 SHALL move IDLE->BURST on a handshake with out_last=0.
REQ-026 SHALL move BURST->IDLE on a handshake with out_last=1.
REQ-027 SHALL stay in IDLE on a single-beat burst (handshake with out_last=1 from IDLE).
REQ-028 SHALL drive in_burst = (state==BURST).
REQ-029 SHALL keep FIFO pointers ($clog2(FIFO_DEPTH)+1 bits) wrapping modulo 2*FIFO_DEPTH; full/empty come from the MSB compare.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-burst, asynchronously clear out_valid, occupancy, the FIFO pointers and the state machine (to IDLE), and discard all stored beats.
REQ-031 SHALL reset out_id, out_data, out_resp, out_last and out_tagid to 0.
REQ-032 SHALL drive in_ready=1 from the first edge after reset release.

Configuration
REQ-033 SHALL, with ORB_STATS_EN defined, add output ports stat_beats[31:0], stat_bursts[15:0] and stat_errs[15:0].
REQ-034 SHALL, with ORB_STATS_EN defined, increment stat_beats on each output handshake, stat_bursts on each output handshake with last=1, and stat_errs on each output handshake with out_resp[1]=1; all wrap at max and reset to 0.
REQ-035 SHALL, without ORB_STATS_EN, omit these ports and counters; behaviour is otherwise identical.

Structure
REQ-036 SHALL place the packed struct r_beat_t (id, data, resp, last, tagid), the state enum and the RESP_OKAY/EXOKAY/SLVERR/DECERR constants in shared package rob_pkg.
REQ-037 SHALL implement storage as sub-module rsp_fifo: show-ahead, parameterised width/depth, full/empty outputs.

Verification
REQ-038 SHALL cover: reset, then push 1 beat (id=3, data=0xA5A5A5A5, last=1) with out_ready=1 -> out_valid=1 after edge 2, fields match, occupancy returns to 0, in_burst stays 0.
REQ-039 SHALL cover: out_ready=0, push 17 beats (FIFO_DEPTH=16) -> in_ready=0 at occupancy 17; the 18th beat is not accepted; out_* stay stable.
REQ-040 SHALL cover: full buffer, out_ready=1 and in_valid=1 for 40 cycles -> 1 beat/cycle out, order preserved across pointer wrap, no drops.
REQ-041 SHALL cover: a 4-beat burst with last on beat 4 and random out_ready -> in_burst=1 from the beat-1 handshake through the beat-4 handshake, then 0.
REQ-042 SHALL cover: rst_n pulsed low mid-burst with 5 beats held -> out_valid=0, occupancy=0, state IDLE immediately.
REQ-043 SHALL cover, with ORB_STATS_EN: 3 bursts of 2 beats, one with resp=SLVERR on both beats -> stat_beats=6, stat_bursts=3, stat_errs=2.
